servo_pwm_gen: RTL

Downstream stage of the servo command controller. Takes the 10-bit duty code that the controller produces and drives the servo's PWM line. The period is fixed at 20 ms. The pulse width is the duty code times a fixed unit of clock cycles. A new duty code only takes effect on a period boundary, so no glitched or truncated pulses ever reach the servo.

---
 rtl/servo_pwm_gen_pkg.sv | 26 ++
 rtl/servo_pwm_gen_if.sv | 28 ++
 rtl/servo_pwm_gen_duty_shaper.sv | 46 ++++
 rtl/servo_pwm_gen.sv | 98 +++++++++
 4 files changed

// File: rtl/servo_pwm_gen_pkg.sv
// Shared servo constants and duty-code helpers, reused by the upstream controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package servo_pkg;

    localparam int DUTY_W                = 10;
    localparam int DUTY_NEUTRAL          = 45;
    localparam int DUTY_MIN              = 15;
    localparam int DUTY_MAX              = 75;
    localparam int PWM_PERIOD_CYCLES     = 500000;
    localparam int DUTY_UNIT_CYCLES_DEF  = 833;
    localparam int SLEW_STEP_DEF         = 5;

    typedef logic [DUTY_W-1:0] duty_t;

    // Saturate a requested duty code into the legal [lo, hi] window.
    function automatic duty_t clamp_duty(input duty_t x, input duty_t lo, input duty_t hi);
        if (x < lo)
            return lo;
        else if (x > hi)
            return hi;
        else
            return x;
    endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Duty command in, PWM line and status out, grouped for the servo PWM stage.
// Latency: n/a (wiring only).
// Backpressure: none; the duty code is sampled once per period.
interface servo_pwm_gen_if;
    import servo_pkg::*;

    duty_t duty_cycle_input;
    logic  servoSignal;
    logic  period_start;
    duty_t duty_active;

    // Upstream side: drives the duty request, observes the PWM stage.
    modport master (
        output duty_cycle_input,
        input  servoSignal,
        input  period_start,
        input  duty_active
    );

    // PWM generator side.
    modport slave (
        input  duty_cycle_input,
        output servoSignal,
        output period_start,
        output duty_active
    );

endinterface

// File: rtl/servo_pwm_gen_duty_shaper.sv
// Clamps the requested duty code and (with SLEW_LIMIT_EN) limits its per-period step.
// Latency: combinational.
// Backpressure: none.
module servo_duty_shaper
    import servo_pkg::*;
#(
    parameter int DUTY_MIN  = servo_pkg::DUTY_MIN,
    parameter int DUTY_MAX  = servo_pkg::DUTY_MAX,
    parameter int SLEW_STEP = servo_pkg::SLEW_STEP_DEF
) (
    input  duty_t duty_active,
    input  duty_t duty_cycle_input,
    output duty_t next_duty
);

    if (SLEW_STEP < 1) begin : g_bad_step
        $error("servo_duty_shaper: SLEW_STEP must be at least 1");
    end

    duty_t target;

    // Pick the duty code to apply in the next period.
    always_comb begin
        target    = clamp_duty(duty_cycle_input, duty_t'(DUTY_MIN), duty_t'(DUTY_MAX));
        next_duty = duty_active;
`ifdef SLEW_LIMIT_EN
        // Move toward the target by at most SLEW_STEP; land exactly on it, never past.
        if (target > duty_active) begin
            if ((target - duty_active) > duty_t'(SLEW_STEP))
                next_duty = duty_active + duty_t'(SLEW_STEP);
            else
                next_duty = target;
        end else if (target < duty_active) begin
            if ((duty_active - target) > duty_t'(SLEW_STEP))
                next_duty = duty_active - duty_t'(SLEW_STEP);
            else
                next_duty = target;
        end
`else
        // Jump straight to the target; hold the current code when nothing changed.
        if (target != duty_active)
            next_duty = target;
`endif
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed period, pulse = duty_active * DUTY_UNIT_CYCLES; optional SLEW_LIMIT_EN.
// Latency: a new duty code is sampled on the last period cycle and shows from the next period start.
// Backpressure: none; requests between sample points are ignored, the running pulse is never altered.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES    = servo_pkg::PWM_PERIOD_CYCLES,
    parameter int DUTY_UNIT_CYCLES = servo_pkg::DUTY_UNIT_CYCLES_DEF,
    parameter int DUTY_MIN         = servo_pkg::DUTY_MIN,
    parameter int DUTY_MAX         = servo_pkg::DUTY_MAX,
    parameter int DUTY_RESET       = servo_pkg::DUTY_NEUTRAL,
    parameter int SLEW_STEP        = servo_pkg::SLEW_STEP_DEF
) (
    input  logic            clk25mhz,
    input  logic            reset,
    servo_pwm_gen_if.slave  bus
);

    localparam int PC_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int UC_W  = (DUTY_UNIT_CYCLES > 1) ? $clog2(DUTY_UNIT_CYCLES) : 1;
    localparam int UI_W  = $clog2(PERIOD_CYCLES / DUTY_UNIT_CYCLES + 2);
    localparam int CMP_W = (UI_W > DUTY_W) ? UI_W : DUTY_W;

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERIOD_CYCLES - 1);
    localparam logic [UC_W-1:0] UC_LAST = UC_W'(DUTY_UNIT_CYCLES - 1);

    // The widest pulse must leave a low phase inside the period.
    if (DUTY_MAX * DUTY_UNIT_CYCLES >= PERIOD_CYCLES) begin : g_bad_period
        $error("servo_pwm_gen: DUTY_MAX*DUTY_UNIT_CYCLES must be below PERIOD_CYCLES");
    end
    if (DUTY_RESET < DUTY_MIN || DUTY_RESET > DUTY_MAX || DUTY_MIN > DUTY_MAX) begin : g_bad_range
        $error("servo_pwm_gen: need DUTY_MIN <= DUTY_RESET <= DUTY_MAX");
    end

    logic [PC_W-1:0] period_cnt, period_cnt_n;
    logic [UC_W-1:0] unit_cnt,   unit_cnt_n;
    logic [UI_W-1:0] unit_idx,   unit_idx_n;
    duty_t           duty_active, duty_n, next_duty;
    logic            started;      // low until the first period after reset has begun
    logic            servo_q, period_start_q;
    logic            wrap, load, pulse_n;

    servo_duty_shaper #(
        .DUTY_MIN  (DUTY_MIN),
        .DUTY_MAX  (DUTY_MAX),
        .SLEW_STEP (SLEW_STEP)
    ) u_shaper (
        .duty_active      (duty_active),
        .duty_cycle_input (bus.duty_cycle_input),
        .next_duty        (next_duty)
    );

    // Next-state of the period/unit counters and the pulse level they imply.
    always_comb begin
        wrap         = !started || (period_cnt == PC_LAST);
        load         = started && (period_cnt == PC_LAST);
        duty_n       = load ? next_duty : duty_active;
        period_cnt_n = '0;
        unit_cnt_n   = '0;
        unit_idx_n   = '0;
        if (!wrap) begin
            period_cnt_n = period_cnt + 1'b1;
            if (unit_cnt == UC_LAST) begin
                unit_idx_n = unit_idx + 1'b1;
            end else begin
                unit_cnt_n = unit_cnt + 1'b1;
                unit_idx_n = unit_idx;
            end
        end
        pulse_n = CMP_W'(unit_idx_n) < CMP_W'(duty_n);
    end

    // Register counters, the applied duty code and both outputs.
    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            started        <= 1'b0;
            period_cnt     <= '0;
            unit_cnt       <= '0;
            unit_idx       <= '0;
            duty_active    <= duty_t'(DUTY_RESET);
            servo_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            started        <= 1'b1;
            period_cnt     <= period_cnt_n;
            unit_cnt       <= unit_cnt_n;
            unit_idx       <= unit_idx_n;
            duty_active    <= duty_n;
            servo_q        <= pulse_n;
            period_start_q <= wrap;
        end
    end

    assign bus.servoSignal  = servo_q;
    assign bus.period_start = period_start_q;
    assign bus.duty_active  = duty_active;

endmodule
